led_shift_driver: RTL and testbench

Serial LED driver that sits directly downstream of the GPIO register block. It accepts a parallel LED word, already ordered and inverted by GPIO, and shifts it MSB-first into an external 74HC164/595-style shift-register chain. It generates the serial clock, data, clear and latch-strobe pins. GPIO pulses `Start` whenever a refresh is required; this block owns all board-side LED pin timing.

---
 rtl/led_shift_driver.sv | 132 +++++++++++++
 tb/tb_led_shift_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_driver.sv
// Serial LED driver: shifts a parallel LED word MSB-first into a 74HC164/595-style
// chain and produces the serial clock, data, clear and latch-strobe pins.
module led_shift_driver #(
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [DATA_BITS-1:0] P_Data,
  output logic                 led_clk,
  output logic                 led_sout,
  output logic                 led_clrn,
  output logic                 LED_PEN,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int CNT_W = $clog2(DATA_BITS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 led_clk_q, led_clk_d;
  logic                 sout_q, sout_d;
  logic                 clrn_q;
  logic                 pen_q, pen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    // NOTE: every _d signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    led_clk_d = led_clk_q;
    sout_d    = sout_q;

    case (state_q)
      S_IDLE: begin
        led_clk_d = 1'b0;
        if (Start) state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d   = P_Data;
        cnt_d     = CNT_W'(DATA_BITS);
        div_d     = '0;
        led_clk_d = 1'b0;
        sout_d    = P_Data[DATA_BITS-1];
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!led_clk_q) begin
            led_clk_d = 1'b1;
          end else begin
            // End of the high phase: advance to the next bit as the clock falls.
            led_clk_d = 1'b0;
            shreg_d   = shreg_q << 1;
            cnt_d     = cnt_q - 1'b1;
            sout_d    = shreg_d[DATA_BITS-1];
            if (cnt_q == CNT_W'(1)) state_d = S_LATCH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LATCH: begin
        led_clk_d = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status pins are registered alongside the state they describe.
  assign pen_d  = (state_d == S_LATCH);
  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_q == S_LATCH) && (state_d == S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      led_clk_q <= 1'b0;
      sout_q    <= 1'b0;
      clrn_q    <= 1'b0;
      pen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      led_clk_q <= led_clk_d;
      sout_q    <= sout_d;
      clrn_q    <= 1'b1;
      pen_q     <= pen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign led_clk  = led_clk_q;
  assign led_sout = sout_q;
  assign led_clrn = clrn_q;
  assign LED_PEN  = pen_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Randomized scoreboard bench for led_shift_driver: a default instance (16 bits, divide 4)
// and a corner instance (4 bits, divide 1), checked against frame-level expectations.
module tb_led_shift_driver;

  typedef struct {
    int          inst;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_seen = 1'b1;
  int          cyc = 0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] pdata0 = '0;
  logic [3:0]  pdata1 = '0;
  logic        lclk0, sout0, clrn0, pen0, busy0, done0;
  logic        lclk1, sout1, clrn1, pen1, busy1, done1;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  // Per-instance monitor state, index 0 = default instance, 1 = corner instance.
  logic        prev_clk [2];
  logic        prev_busy[2];
  logic        prev_sout[2];
  logic [15:0] bits     [2];
  int          load_cyc [2];
  int          rise_cyc [2];
  int          rises    [2];
  int          pen_cnt  [2];
  int          busy_cnt [2];
  int          load_cnt [2];
  int          last_gap [2];
  int          pen_total[2];

  led_shift_driver u_big (
    .clk(clk), .rst(rst), .Start(start0), .P_Data(pdata0),
    .led_clk(lclk0), .led_sout(sout0), .led_clrn(clrn0),
    .LED_PEN(pen0), .busy(busy0), .done(done0)
  );

  led_shift_driver #(.DATA_BITS(4), .CLK_DIV(1)) u_small (
    .clk(clk), .rst(rst), .Start(start1), .P_Data(pdata1),
    .led_clk(lclk1), .led_sout(sout1), .led_clrn(clrn1),
    .LED_PEN(pen1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int cd_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int nb_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  // Frame length from LOAD through the last latch cycle.
  function automatic int len_of(input int i);
    return 1 + 2 * cd_of(i) * nb_of(i) + cd_of(i);
  endfunction

  // cyc here is the index of the most recent rising edge; busy first seen at load_cyc.
  task automatic mon(input int i, input logic c, input logic s, input logic pen,
                     input logic b, input logic dn);
    int   cd = cd_of(i);
    exp_t e;
    if (!rst_seen) begin
      if (b && !prev_busy[i]) begin
        if (load_cnt[i] > 0) last_gap[i] = cyc - load_cyc[i];
        load_cnt[i]++;
        load_cyc[i] = cyc;
        rises[i]    = 0;
        bits[i]     = '0;
        pen_cnt[i]  = 0;
        busy_cnt[i] = 0;
      end
      if (b) busy_cnt[i]++;
      if (s !== prev_sout[i])
        check($sformatf("sout_change_point[%0d]", i), (prev_clk[i] && !c) || (cyc == load_cyc[i] + 1), 1);
      if (c && !prev_clk[i]) begin
        check($sformatf("rise_time[%0d]", i), cyc, load_cyc[i] + 1 + cd + 2 * cd * rises[i]);
        bits[i]     = {bits[i][14:0], s};
        rises[i]++;
        rise_cyc[i] = cyc;
      end
      if (!c && prev_clk[i]) check($sformatf("high_width[%0d]", i), cyc - rise_cyc[i], cd);
      if (pen) begin
        pen_cnt[i]++;
        pen_total[i]++;
        check($sformatf("pen_clk_low[%0d]", i), c, 0);
      end
      if (dn) begin
        check($sformatf("done_expected[%0d]", i), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_inst", i, e.inst);
          check($sformatf("frame_bits[%0d]", i), bits[i], e.data);
          check($sformatf("frame_rises[%0d]", i), rises[i], nb_of(i));
          check($sformatf("frame_pen[%0d]", i), pen_cnt[i], cd);
          check($sformatf("frame_busy[%0d]", i), busy_cnt[i], len_of(i));
          check($sformatf("done_time[%0d]", i), cyc, load_cyc[i] + len_of(i));
        end
      end
    end
    prev_clk[i]  = c;
    prev_busy[i] = b;
    prev_sout[i] = s;
  endtask

  always @(negedge clk) begin
    mon(0, lclk0, sout0, pen0, busy0, done0);
    mon(1, lclk1, sout1, pen1, busy1, done1);
  end

  task automatic set_start(input int i, input logic v);
    if (i == 0) start0 = v;
    else        start1 = v;
  endtask

  task automatic set_data(input int i, input logic [15:0] d);
    if (i == 0) pdata0 = d;
    else        pdata1 = d[3:0];
  endtask

  // One Start pulse; the word present at LOAD is the expected serial stream.
  task automatic run_frame(input int i, input logic [15:0] d, input bit extra, input bit chg5);
    int   cd = cd_of(i);
    int   e0, lc;
    exp_t x;
    @(negedge clk);
    lc = load_cnt[i];
    set_data(i, d);
    set_start(i, 1'b1);
    x.inst = i;
    x.data = (i == 0) ? d : (d & 16'h000F);
    exp_q.push_back(x);
    e0 = cyc + 1;
    @(negedge clk);
    set_start(i, 1'b0);
    @(negedge clk);
    while (cyc < e0 + len_of(i) + 2) begin
      if (chg5) begin
        if (cyc == e0 + 1 + cd + 8 * cd) set_data(i, 16'h0000);
      end else begin
        set_data(i, 16'($urandom));
      end
      set_start(i, extra && (cyc == e0 + 3));
      @(negedge clk);
    end
    set_start(i, 1'b0);
    check($sformatf("frame_loads[%0d]", i), load_cnt[i] - lc, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e0, lc, p0;
    logic [15:0] d;
    exp_t        x;
    for (int i = 0; i < 2; i++) begin
      prev_clk[i]  = 1'b0;
      prev_busy[i] = 1'b0;
      prev_sout[i] = 1'b0;
      bits[i]      = '0;
      load_cyc[i]  = 0;
      rise_cyc[i]  = 0;
      rises[i]     = 0;
      pen_cnt[i]   = 0;
      busy_cnt[i]  = 0;
      load_cnt[i]  = 0;
      last_gap[i]  = 0;
      pen_total[i] = 0;
    end

    // Reset held 3 cycles: every output low.
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", {lclk0, sout0, clrn0, pen0, busy0, done0,
                           lclk1, sout1, clrn1, pen1, busy1, done1}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("clrn_release", {clrn0, clrn1}, 2'b11);
    check("idle_after_rst", {lclk0, pen0, busy0, done0, lclk1, pen1, busy1, done1}, 0);
    repeat (5) @(negedge clk);
    check("stays_idle", {busy0, busy1}, 0);

    // Default-instance frames: fixed word, mid-frame data change, ignored extra Start.
    run_frame(0, 16'hA5C3, 1'b0, 1'b0);
    run_frame(0, 16'hFFFF, 1'b0, 1'b1);
    run_frame(0, 16'($urandom), 1'b1, 1'b0);

    // Start held: done cycle re-enters IDLE, so LOADs are len+1 edges apart
    // (LOAD cycles T+1 and T+135 for the defaults); 200 cycles covers exactly 2.
    @(negedge clk);
    lc = load_cnt[0];
    d  = 16'($urandom);
    set_data(0, d);
    set_start(0, 1'b1);
    e0 = cyc + 1;
    x.inst = 0;
    x.data = d;
    exp_q.push_back(x);
    exp_q.push_back(x);
    repeat (200) @(negedge clk);
    set_start(0, 1'b0);
    while (cyc < e0 + 2 * len_of(0) + 6) @(negedge clk);
    check("b2b_loads", load_cnt[0] - lc, 2);
    check("b2b_gap", last_gap[0], len_of(0) + 1);

    // Reset at the 8th led_clk rise aborts the frame with no strobe and no done.
    @(negedge clk);
    p0 = pen_total[0];
    set_data(0, 16'($urandom));
    set_start(0, 1'b1);
    e0 = cyc + 1;
    @(negedge clk);
    set_start(0, 1'b0);
    while (cyc < e0 + 1 + 15 * cd_of(0)) begin
      set_data(0, 16'($urandom));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_rises", rises[0], 8);
    check("abort_outs", {lclk0, busy0, clrn0, pen0, done0}, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_pen", pen_total[0] - p0, 0);
    check("abort_clrn", clrn0, 1);

    // Random frames with random gaps.
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(0, 16'($urandom), k == 2, 1'b0);
    end

    // Corner instance: 4 bits, divide-by-1.
    run_frame(1, 16'h0009, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(1, 16'($urandom), k == 1, 1'b0);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
